// File: rtl/memory_sync.sv
`timescale 1ns/1ps
// memory_sync: single-port synchronous word memory with byte-masked writes.
// Each request is captured in IDLE and answered with a one-cycle ack exactly
// LATENCY cycles after the capture cycle. Requests arriving while a request
// is in flight are ignored. The storage array is never cleared by reset.
module memory_sync #(
  parameter int unsigned WIDTH   = 128,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 master_enable,
  input  logic                 read_write,
  input  logic [31:0]          addr,
  input  logic [WIDTH/8-1:0]   byte_enable,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     data_out,
  output logic                 ack,
  output logic                 busy
);

  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The BUSY counter never holds more than LATENCY-2.
  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);
  // With LATENCY=1 the access happens on the capture edge itself.
  localparam bit FAST = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    rw_q;
  logic [BYTES-1:0]        be_q;
  logic [WIDTH-1:0]        din_q;
  logic [WIDTH-1:0]        dout_q;
  logic                    ack_q;
  logic                    busy_q;

  logic [WIDTH-1:0]        mem_q [DEPTH];

  logic [IDX_W-1:0]        in_idx_c;
  logic                    access_c;
  logic [IDX_W-1:0]        acc_idx_c;
  logic                    acc_rw_c;
  logic [BYTES-1:0]        acc_be_c;
  logic [WIDTH-1:0]        acc_din_c;
  logic [WIDTH-1:0]        rd_word_c;

  // Word index of the live request: drop the byte offset, wrap modulo DEPTH.
  assign in_idx_c = IDX_W'((addr / 32'(BYTES)) % 32'(DEPTH));

  // Select the access source (live inputs on a LATENCY=1 capture, captured
  // request otherwise) and decide whether the array is accessed this edge.
  always_comb begin
    access_c  = 1'b0;
    acc_idx_c = idx_q;
    acc_rw_c  = rw_q;
    acc_be_c  = be_q;
    acc_din_c = din_q;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (FAST && master_enable) begin
            access_c  = 1'b1;
            acc_idx_c = in_idx_c;
            acc_rw_c  = read_write;
            acc_be_c  = byte_enable;
            acc_din_c = data_in;
          end
        end
        S_BUSY: begin
          if (cnt_q == '0) begin
            access_c = 1'b1;
          end
        end
        default: begin
          access_c = 1'b0;
        end
      endcase
    end
  end

  assign rd_word_c = mem_q[acc_idx_c];

  // Byte-masked array write; no reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (access_c && acc_rw_c) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (acc_be_c[b]) begin
          mem_q[acc_idx_c][8*b +: 8] <= acc_din_c[8*b +: 8];
        end
      end
    end
  end

  // Request FSM: capture, latency countdown, one-cycle response, registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (master_enable) begin
            idx_q  <= in_idx_c;
            rw_q   <= read_write;
            be_q   <= byte_enable;
            din_q  <= data_in;
            busy_q <= 1'b1;
            if (FAST) begin
              state_q <= S_RESP;
              ack_q   <= 1'b1;
              if (!read_write) begin
                dout_q <= rd_word_c;
              end
            end else begin
              state_q <= S_BUSY;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        S_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q <= S_RESP;
            ack_q   <= 1'b1;
            if (!rw_q) begin
              dout_q <= rd_word_c;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = dout_q;
  assign ack      = ack_q;
  assign busy     = busy_q;

endmodule

// File: doc/memory_sync.md
MEMORY_SYNC -- requirements
Module: memory_sync

Interface
REQ-001 Parameter WIDTH, default 128, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 1024, number of WIDTH-bit words stored.
REQ-003 Parameter LATENCY, default 4, rising edges from request capture to response; SHALL be >= 1.
REQ-004 Localparam BYTES SHALL equal WIDTH/8.
REQ-005 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-006 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-007 master_enable  in  1  request valid from initiator.
REQ-008 read_write  in  1  0 = read, 1 = write.
REQ-009 addr  in  32  byte address; word index = (addr / BYTES) mod DEPTH; low log2(BYTES) bits ignored.
REQ-010 byte_enable  in  BYTES  per-byte write mask; bit i covers data bits [8i+7:8i].
REQ-011 data_in  in  WIDTH  write data.
REQ-012 data_out  out  WIDTH  read data, registered.
REQ-013 ack  out  1  single-cycle response strobe, registered.
REQ-014 busy  out  1  high while a request is in flight (states BUSY, RESP).

Function
REQ-015 States SHALL be IDLE, BUSY, RESP; ack SHALL be 1 only in RESP; busy SHALL be 1 in BUSY and RESP.
REQ-016 In IDLE with master_enable=1 at an edge (E0), addr, read_write, byte_enable, data_in SHALL be captured into internal registers.
REQ-017 At E0: LATENCY=1 -> perform access and enter RESP; else enter BUSY, counter loaded with LATENCY-2.
REQ-018 In BUSY: counter nonzero -> decrement; counter zero -> perform access, enter RESP.
REQ-019 ack SHALL be high during exactly the one cycle following edge E0+LATENCY-1 (i.e. LATENCY cycles after the capture cycle).
REQ-020 RESP SHALL always go to IDLE at the next edge; minimum spacing between two acks is LATENCY+1 cycles.
REQ-021 master_enable and all request inputs SHALL be ignored in BUSY and RESP; only captured values are used.
REQ-022 Deasserting master_enable mid-request SHALL NOT abort it; the access and ack still occur.
REQ-023 Read access: data_out SHALL load the addressed word at the edge entering RESP and hold until the next read access.
REQ-024 Write access: only bytes with byte_enable=1 SHALL be updated; data_out SHALL remain unchanged.
REQ-025 byte_enable is ignored for reads (full word returned).
REQ-026 Addresses beyond DEPTH*BYTES SHALL wrap modulo DEPTH, with no error indication.
REQ-027 A write followed by a read of the same word SHALL return the merged written data.
REQ-028 Memory contents SHALL be uninitialised (X) until written; no reset clears the array.

Reset
REQ-029 reset=1 at an edge SHALL force state IDLE, counter 0, ack 0, busy 0, data_out all-zero.
REQ-030 reset SHALL take priority over any request; a request captured but not yet in RESP SHALL be aborted with no array write and no ack.
REQ-031 master_enable high during the reset edge SHALL NOT be captured; capture starts at the first edge with reset=0.
REQ-032 Memory array contents SHALL be preserved across reset.

Verification
REQ-033 Reset 2 cycles, LATENCY=4: write addr 0x10, data 0xDEADBEEF (low word), byte_enable all 1 -> ack high exactly in 4th cycle after capture, one cycle wide, busy high 4 cycles.
REQ-034 Then read addr 0x10 -> data_out = written word at ack; read addr 0x10 + DEPTH*BYTES -> same word (wrap).
REQ-035 Write 0xFF..FF full word, then write 0x00..00 with byte_enable=0x0001 -> read returns all-ones except byte 0 = 0x00.
REQ-036 master_enable held high continuously, LATENCY=1 -> acks every 2nd cycle; LATENCY=4 -> every 5th; enable dropped after capture -> ack still issued.
REQ-037 Write request issued, reset asserted 2 cycles after capture -> no ack, busy 0, data_out 0; subsequent read of that address returns prior contents.
REQ-038 Random back-to-back read/write traffic vs reference model (10k requests, LATENCY 1..6) -> all read data match, ack count equals request count.
